mem_stage_ctrl: RTL and testbench

//  MEM stage of the 5-stage pipeline: consumes the EX/MEM latch outputs and

---
 rtl/mem_stage_if.sv | 41 ++++
 rtl/mem_stage_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// EX/MEM latch inputs, data-cache bus and MEM/WB latch outputs of the MEM stage.
interface mem_stage_if #(parameter int CNT_W = 16);
  logic        em_valid, em_dREN, em_dWEN;
  logic        em_beq, em_bne, em_jump, em_jr, em_jal, em_lui;
  logic        em_MemtoReg, em_RegWr, em_halt, em_flagZero;
  logic [31:0] em_alu, em_rdat1, em_rdat2, em_pc4, em_ext;
  logic [15:0] em_imm;
  logic [25:0] em_jaddr;
  logic [4:0]  em_wsel;
  logic        ext_hold, dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        mem_stall, pc_redirect;
  logic [31:0] npc;
  logic        wb_valid, wb_RegWr;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat;
  logic        halt;
  logic [CNT_W-1:0] stall_cnt;

  // The MEM stage itself.
  modport slave (
    input  em_valid, em_dREN, em_dWEN, em_beq, em_bne, em_jump, em_jr, em_jal,
           em_lui, em_MemtoReg, em_RegWr, em_halt, em_flagZero, em_alu,
           em_rdat1, em_rdat2, em_pc4, em_ext, em_imm, em_jaddr, em_wsel,
           ext_hold, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, pc_redirect, npc,
           wb_valid, wb_RegWr, wb_wsel, wb_wdat, halt, stall_cnt
  );

  // Whatever surrounds the stage: EX/MEM latch, cache, hazard unit.
  modport master (
    output em_valid, em_dREN, em_dWEN, em_beq, em_bne, em_jump, em_jr, em_jal,
           em_lui, em_MemtoReg, em_RegWr, em_halt, em_flagZero, em_alu,
           em_rdat1, em_rdat2, em_pc4, em_ext, em_imm, em_jaddr, em_wsel,
           ext_hold, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, pc_redirect, npc,
           wb_valid, wb_RegWr, wb_wsel, wb_wdat, halt, stall_cnt
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage: data-cache request/hold, branch resolution, writeback value and
// MEM/WB latch.
//  state  | meaning
//  IDLE   | no access outstanding; a zero-wait hit completes here
//  ACCESS | request issued, waiting for dhit
//  DONE   | access finished while frozen; suppress re-issue until released
module mem_stage_ctrl #(
  parameter int CNT_W = 16
) (
  input logic      CLK,
  input logic      nRST,
  mem_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  logic [31:0]      load_q;
  logic             halt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wb_valid_q, wb_regwr_q;
  logic [4:0]       wb_wsel_q;
  logic [31:0]      wb_wdat_q;

  logic        req, issue, hit, stall, advance, take;
  logic [31:0] wdat, npc;
  logic [4:0]  wsel;

  // nRST gating makes an outstanding request vanish the instant reset falls.
  assign req     = nRST & bus.em_valid & (bus.em_dREN | bus.em_dWEN) & ~halt_q;
  assign issue   = req & (state != DONE);
  assign hit     = issue & bus.dhit;
  assign stall   = issue & ~bus.dhit;
  assign advance = nRST & bus.em_valid & ~stall & ~bus.ext_hold;
  assign take    = (bus.em_beq & bus.em_flagZero) | (bus.em_bne & ~bus.em_flagZero);
  assign wsel    = bus.em_jal ? 5'd31 : bus.em_wsel;

  assign bus.dmemREN     = issue & bus.em_dREN;
  assign bus.dmemWEN     = issue & bus.em_dWEN;
  assign bus.dmemaddr    = bus.em_alu;
  assign bus.dmemstore   = bus.em_rdat2;
  assign bus.mem_stall   = stall;
  assign bus.pc_redirect = advance & (take | bus.em_jump | bus.em_jal | bus.em_jr);
  assign bus.npc         = npc;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_RegWr    = wb_regwr_q;
  assign bus.wb_wsel     = wb_wsel_q;
  assign bus.wb_wdat     = wb_wdat_q;
  assign bus.halt        = halt_q;
  assign bus.stall_cnt   = cnt_q;

  // Redirect target: register jump, absolute jump, or PC-relative branch.
  always_comb begin
    npc = bus.em_pc4 + (bus.em_ext << 2);
    if (bus.em_jr)
      npc = bus.em_rdat1;
    else if (bus.em_jump | bus.em_jal)
      npc = {bus.em_pc4[31:28], bus.em_jaddr, 2'b00};
  end

  // Writeback value; a load bypasses load_q on the cycle the data arrives.
  always_comb begin
    wdat = bus.em_alu;
    if (bus.em_jal)
      wdat = bus.em_pc4;
    else if (bus.em_lui)
      wdat = {bus.em_imm, 16'h0000};
    else if (bus.em_MemtoReg)
      wdat = bus.dhit ? bus.dmemload : load_q;
  end

  // Cache access sequencing and load data capture.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      load_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            load_q <= bus.dmemload;
            if (bus.ext_hold) state <= DONE;
          end else if (req) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (hit) begin
            load_q <= bus.dmemload;
            state  <= bus.ext_hold ? DONE : IDLE;
          end else if (!req) begin
            state <= IDLE;
          end
        end
        DONE: begin
          if (!bus.ext_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB latch: load on advance, bubble when empty and free, else hold.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_valid_q <= 1'b0;
      wb_regwr_q <= 1'b0;
      wb_wsel_q  <= '0;
      wb_wdat_q  <= '0;
    end else if (advance) begin
      wb_valid_q <= 1'b1;
      wb_regwr_q <= bus.em_RegWr;
      wb_wsel_q  <= wsel;
      wb_wdat_q  <= wdat;
    end else if (!bus.em_valid && !bus.ext_hold) begin
      wb_valid_q <= 1'b0;
      wb_regwr_q <= 1'b0;
    end
  end

  // Sticky halt once a halt instruction leaves the stage.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      halt_q <= 1'b0;
    else if (advance && bus.em_halt)
      halt_q <= 1'b1;
  end

  // Saturating count of memory stall cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      cnt_q <= '0;
    else if (stall && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for the MEM stage controller.
module tb_mem_stage_ctrl;
  localparam int CW = 4;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int checks = 0;
  int errors = 0;

  mem_stage_if #(.CNT_W(CW)) bus();
  mem_stage_ctrl #(.CNT_W(CW)) dut (.CLK(CLK), .nRST(nRST), .bus(bus.slave));

  always #5 CLK = ~CLK;

  typedef struct {
    int          op;        // 0 beq 1 bne 2 j 3 jr 4 jal 5 lui
    logic        fz;
    logic [31:0] pc4, ext, rdat1;
    logic [25:0] jaddr;
    logic [15:0] imm;
    logic        exp_redir;
    logic [31:0] exp_npc;
    logic [4:0]  exp_wsel;
    logic [31:0] exp_wdat;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.em_valid = 0; bus.em_dREN = 0; bus.em_dWEN = 0; bus.em_beq = 0; bus.em_bne = 0;
    bus.em_jump = 0; bus.em_jr = 0; bus.em_jal = 0; bus.em_lui = 0; bus.em_MemtoReg = 0;
    bus.em_RegWr = 0; bus.em_halt = 0; bus.em_flagZero = 0;
    bus.em_alu = 0; bus.em_rdat1 = 0; bus.em_rdat2 = 0; bus.em_pc4 = 0; bus.em_ext = 0;
    bus.em_imm = 0; bus.em_jaddr = 0; bus.em_wsel = 0;
    bus.ext_hold = 0; bus.dhit = 0; bus.dmemload = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle_inputs();
    nRST = 0;
    repeat (2) @(negedge CLK);
    nRST = 1;
  endtask

  task automatic add_vec(input int op, input logic fz, input logic [31:0] pc4, ext, rdat1,
                         input logic [25:0] jaddr, input logic [15:0] imm, input logic redir,
                         input logic [31:0] npc, input logic [4:0] wsel, input logic [31:0] wdat);
    vec_t v;
    v.op = op; v.fz = fz; v.pc4 = pc4; v.ext = ext; v.rdat1 = rdat1; v.jaddr = jaddr;
    v.imm = imm; v.exp_redir = redir; v.exp_npc = npc; v.exp_wsel = wsel; v.exp_wdat = wdat;
    vecs.push_back(v);
  endtask

  // reference model state
  logic        m_served, m_halt, m_wbv, m_wbr;
  logic [4:0]  m_wsel;
  logic [31:0] m_wdat, m_load;
  int          m_cnt;

  initial begin
    int n_acc;
    logic consume, is_mem, e_issue, e_stall, e_adv, e_take, e_redir;
    logic [31:0] e_npc, e_wdat;
    int kind;

    idle_inputs();
    nRST = 0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_wb_valid", 32'(bus.wb_valid), 0);
    chk("rst_wb_regwr", 32'(bus.wb_RegWr), 0);
    chk("rst_wb_wdat", bus.wb_wdat, 0);
    chk("rst_halt", 32'(bus.halt), 0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    @(negedge CLK); nRST = 1;

    // 1: load with zero-wait hit
    @(negedge CLK);
    bus.em_valid = 1; bus.em_dREN = 1; bus.em_MemtoReg = 1; bus.em_RegWr = 1;
    bus.em_alu = 32'h40; bus.em_wsel = 5'd5; bus.dhit = 1; bus.dmemload = 32'hDEAD_BEEF;
    #1;
    chk("t1_dmemREN", 32'(bus.dmemREN), 1);
    chk("t1_mem_stall", 32'(bus.mem_stall), 0);
    chk("t1_dmemaddr", bus.dmemaddr, 32'h40);
    @(posedge CLK); #1;
    chk("t1_wb_wdat", bus.wb_wdat, 32'hDEAD_BEEF);
    chk("t1_wb_regwr", 32'(bus.wb_RegWr), 1);
    chk("t1_wb_wsel", 32'(bus.wb_wsel), 5);
    @(negedge CLK); idle_inputs();
    @(posedge CLK); #1;
    chk("t1_bubble", 32'(bus.wb_valid), 0);

    // 2: store, hit on 4th cycle
    do_reset();
    n_acc = 0;
    bus.em_valid = 1; bus.em_dWEN = 1; bus.em_alu = 32'h80; bus.em_rdat2 = 32'h1234;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge CLK);
      bus.dhit = (k == 3);
      #1;
      if (bus.dmemWEN) n_acc++;
      chk("t2_stall", 32'(bus.mem_stall), (k < 3) ? 1 : 0);
      chk("t2_dmemstore", bus.dmemstore, 32'h1234);
      @(posedge CLK);
    end
    @(negedge CLK); idle_inputs();
    #1;
    if (bus.dmemWEN) n_acc++;
    chk("t2_wen_cycles", n_acc, 4);
    chk("t2_stall_cnt", 32'(bus.stall_cnt), 3);

    // 3: load hits under ext_hold, held two cycles
    @(negedge CLK);
    n_acc = 0;
    bus.em_valid = 1; bus.em_dREN = 1; bus.em_MemtoReg = 1; bus.em_RegWr = 1;
    bus.em_wsel = 5'd9; bus.ext_hold = 1; bus.dhit = 1; bus.dmemload = 32'hCAFE_F00D;
    #1;
    if (bus.dmemREN) n_acc++;
    chk("t3_stall_hit", 32'(bus.mem_stall), 0);
    @(negedge CLK); bus.dhit = 0; bus.dmemload = 32'h0;
    #1;
    if (bus.dmemREN) n_acc++;
    chk("t3_done_ren", 32'(bus.dmemREN), 0);
    chk("t3_done_stall", 32'(bus.mem_stall), 0);
    chk("t3_hold_wb", 32'(bus.wb_RegWr), 0);
    @(negedge CLK); bus.ext_hold = 0;
    #1;
    if (bus.dmemREN) n_acc++;
    @(posedge CLK); #1;
    chk("t3_wb_wdat", bus.wb_wdat, 32'hCAFE_F00D);
    chk("t3_accesses", n_acc, 1);
    @(negedge CLK); idle_inputs();

    // 4/5: branch and jump table
    add_vec(0, 1, 32'h100, 32'h4, 0, 0, 0, 1, 32'h110, 5'd7, 32'h5555);
    add_vec(1, 1, 32'h100, 32'h4, 0, 0, 0, 0, 32'h110, 5'd7, 32'h5555);
    add_vec(1, 0, 32'h100, 32'hFFFF_FFFF, 0, 0, 0, 1, 32'hFC, 5'd7, 32'h5555);
    add_vec(4, 0, 32'h200, 0, 0, 26'h40, 0, 1, 32'h100, 5'd31, 32'h200);
    add_vec(3, 0, 32'h300, 0, 32'h1234_5678, 0, 0, 1, 32'h1234_5678, 5'd7, 32'h5555);
    add_vec(2, 0, 32'hA000_0004, 0, 0, 26'h3FF_FFFF, 0, 1, 32'hAFFF_FFFC, 5'd7, 32'h5555);
    add_vec(5, 0, 0, 0, 0, 0, 16'hBEEF, 0, 32'h0, 5'd7, 32'hBEEF_0000);
    add_vec(0, 0, 32'hFFFF_FFFC, 32'h1, 0, 0, 0, 0, 32'h0, 5'd7, 32'h5555);
    foreach (vecs[i]) begin
      @(negedge CLK);
      idle_inputs();
      bus.em_valid = 1; bus.em_RegWr = 1; bus.em_alu = 32'h5555; bus.em_wsel = 5'd7;
      bus.em_beq = (vecs[i].op == 0); bus.em_bne = (vecs[i].op == 1);
      bus.em_jump = (vecs[i].op == 2); bus.em_jr = (vecs[i].op == 3);
      bus.em_jal = (vecs[i].op == 4); bus.em_lui = (vecs[i].op == 5);
      bus.em_flagZero = vecs[i].fz; bus.em_pc4 = vecs[i].pc4; bus.em_ext = vecs[i].ext;
      bus.em_rdat1 = vecs[i].rdat1; bus.em_jaddr = vecs[i].jaddr; bus.em_imm = vecs[i].imm;
      #1;
      chk($sformatf("vec%0d_redirect", i), 32'(bus.pc_redirect), 32'(vecs[i].exp_redir));
      chk($sformatf("vec%0d_npc", i), bus.npc, vecs[i].exp_npc);
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_wsel", i), 32'(bus.wb_wsel), 32'(vecs[i].exp_wsel));
      chk($sformatf("vec%0d_wdat", i), bus.wb_wdat, vecs[i].exp_wdat);
    end
    @(negedge CLK); idle_inputs();
    #1;
    chk("redirect_one_cycle", 32'(bus.pc_redirect), 0);

    // stall counter saturation
    do_reset();
    bus.em_valid = 1; bus.em_dREN = 1; bus.em_MemtoReg = 1;
    repeat (20) @(negedge CLK);
    #1;
    chk("cnt_saturate", 32'(bus.stall_cnt), 32'((1 << CW) - 1));
    bus.dhit = 1;
    @(posedge CLK); #1;
    chk("cnt_hold_max", 32'(bus.stall_cnt), 32'((1 << CW) - 1));

    // randomized run against the reference model
    do_reset();
    m_served = 0; m_halt = 0; m_wbv = 0; m_wbr = 0; m_wsel = 0; m_wdat = 0; m_load = 0;
    m_cnt = 0; consume = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge CLK);
      if (consume) begin
        idle_inputs();
        kind = $urandom_range(0, 5);
        bus.em_valid = ($urandom_range(0, 3) != 0);
        bus.em_alu = $urandom; bus.em_rdat1 = $urandom; bus.em_rdat2 = $urandom;
        bus.em_pc4 = $urandom; bus.em_ext = $urandom; bus.em_imm = 16'($urandom);
        bus.em_jaddr = 26'($urandom); bus.em_wsel = 5'($urandom);
        bus.em_flagZero = 1'($urandom_range(0, 1));
        case (kind)
          0: begin bus.em_dREN = 1; bus.em_MemtoReg = 1; bus.em_RegWr = 1; end
          1: bus.em_dWEN = 1;
          2: if ($urandom_range(0, 1) != 0) bus.em_beq = 1; else bus.em_bne = 1;
          3: case ($urandom_range(0, 2))
               0: bus.em_jump = 1;
               1: begin bus.em_jal = 1; bus.em_RegWr = 1; end
               default: bus.em_jr = 1;
             endcase
          4: begin bus.em_lui = 1; bus.em_RegWr = 1; end
          default: bus.em_RegWr = 1;
        endcase
      end
      bus.ext_hold = ($urandom_range(0, 3) == 0);
      is_mem  = bus.em_valid & (bus.em_dREN | bus.em_dWEN) & ~m_halt;
      e_issue = is_mem & ~m_served;
      bus.dhit = e_issue && ($urandom_range(0, 2) == 0);
      bus.dmemload = $urandom;
      e_stall = e_issue & ~bus.dhit;
      e_adv   = bus.em_valid & ~e_stall & ~bus.ext_hold;
      e_take  = (bus.em_beq & bus.em_flagZero) | (bus.em_bne & ~bus.em_flagZero);
      e_redir = e_adv & (e_take | bus.em_jump | bus.em_jal | bus.em_jr);
      if (bus.em_jr) e_npc = bus.em_rdat1;
      else if (bus.em_jump | bus.em_jal)
        e_npc = (bus.em_pc4 & 32'hF000_0000) + 32'(bus.em_jaddr) * 4;
      else e_npc = bus.em_pc4 + bus.em_ext * 4;
      if (bus.em_jal) e_wdat = bus.em_pc4;
      else if (bus.em_lui) e_wdat = 32'(bus.em_imm) * 65536;
      else if (bus.em_MemtoReg) e_wdat = bus.dhit ? bus.dmemload : m_load;
      else e_wdat = bus.em_alu;
      #1;
      chk("rnd_ren", 32'(bus.dmemREN), 32'(e_issue & bus.em_dREN));
      chk("rnd_wen", 32'(bus.dmemWEN), 32'(e_issue & bus.em_dWEN));
      chk("rnd_stall", 32'(bus.mem_stall), 32'(e_stall));
      chk("rnd_redirect", 32'(bus.pc_redirect), 32'(e_redir));
      chk("rnd_npc", bus.npc, e_npc);
      @(posedge CLK); #1;
      if (e_adv) begin
        m_wbv = 1; m_wbr = bus.em_RegWr; m_wdat = e_wdat;
        m_wsel = bus.em_jal ? 5'd31 : bus.em_wsel;
      end else if (!bus.em_valid && !bus.ext_hold) begin
        m_wbv = 0; m_wbr = 0;
      end
      if (e_issue && bus.dhit) m_load = bus.dmemload;
      m_served = e_adv ? 1'b0 : (m_served | (e_issue & bus.dhit));
      if (e_stall && m_cnt < (1 << CW) - 1) m_cnt++;
      consume = e_adv | (~bus.em_valid & ~bus.ext_hold);
      chk("rnd_wb_valid", 32'(bus.wb_valid), 32'(m_wbv));
      chk("rnd_wb_regwr", 32'(bus.wb_RegWr), 32'(m_wbr));
      chk("rnd_wb_wsel", 32'(bus.wb_wsel), 32'(m_wsel));
      chk("rnd_wb_wdat", bus.wb_wdat, m_wdat);
      chk("rnd_stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
    end

    // 6: reset mid-access, then sticky halt
    do_reset();
    bus.em_valid = 1; bus.em_dREN = 1; bus.em_MemtoReg = 1; bus.em_RegWr = 1;
    @(posedge CLK); #1;
    chk("t6_stalled", 32'(bus.mem_stall), 1);
    #2 nRST = 0;
    #1;
    chk("t6_ren_drop", 32'(bus.dmemREN), 0);
    chk("t6_stall_drop", 32'(bus.mem_stall), 0);
    chk("t6_wb_valid", 32'(bus.wb_valid), 0);
    chk("t6_stall_cnt", 32'(bus.stall_cnt), 0);
    chk("t6_redirect", 32'(bus.pc_redirect), 0);
    @(negedge CLK); nRST = 1; idle_inputs();
    bus.em_valid = 1; bus.em_halt = 1;
    @(posedge CLK); #1;
    chk("t6_halt_set", 32'(bus.halt), 1);
    @(negedge CLK); idle_inputs();
    bus.em_valid = 1; bus.em_dREN = 1; bus.em_MemtoReg = 1;
    #1;
    chk("t6_halt_blocks_req", 32'(bus.dmemREN), 0);
    chk("t6_halt_no_stall", 32'(bus.mem_stall), 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("t6_halt_sticky", 32'(bus.halt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
